bit_vault_rf: RTL and testbench

Parametrised successor to the 4x8 register file: WIDTH x DEPTH storage with one byte-enabled write port and two registered read ports. Adds optional write-to-read bypass, per-entry valid flags and a sequenced bulk-clear engine. Sits as a general scratch/config register store beside datapath blocks in the DesignForge designs.

---
 rtl/bit_vault_pkg.sv | 31 +++
 rtl/bit_vault_rf_if.sv | 42 ++++
 rtl/bit_vault_rd_port.sv | 55 +++++
 rtl/bit_vault_rf.sv | 107 ++++++++++
 tb/tb_bit_vault_rf.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/bit_vault_pkg.sv
// rtl/bit_vault_pkg.sv - shared types and helpers for the bit_vault register file
// Contents:
//   clr_state_t  bulk-clear sequencer states
//   merge_be     byte-enable merge of a new word onto an old word
package bit_vault_pkg;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_SWEEP = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

  // The merge helper works on a fixed wide word; callers cast their
  // WIDTH-bit operands up and cast the result back down.
  localparam int MERGE_W  = 256;
  localparam int MERGE_BE = MERGE_W / 8;

  function automatic logic [MERGE_W-1:0] merge_be(
    input logic [MERGE_W-1:0]  old_word,
    input logic [MERGE_W-1:0]  new_word,
    input logic [MERGE_BE-1:0] be
  );
    logic [MERGE_W-1:0] res;
    res = old_word;
    for (int k = 0; k < MERGE_BE; k++) begin
      if (be[k]) res[8*k +: 8] = new_word[8*k +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/bit_vault_rf_if.sv
// rtl/bit_vault_rf_if.sv - write/read/clear bus of the bit_vault register file
// Signals:
//   we, waddr, wdata, wbe, wr_err       byte-enabled write port and drop pulse
//   re0/1, raddr0/1, rdata0/1, rvalid0/1 two registered read ports
//   entry_valid                         per-entry written flags
//   clr_req, clr_busy, clr_done         bulk-clear request and status
// Modports: master drives requests, slave is the register file.
interface bit_vault_rf_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic                we;
  logic [ADDR_W-1:0]   waddr;
  logic [WIDTH-1:0]    wdata;
  logic [WIDTH/8-1:0]  wbe;
  logic                wr_err;
  logic                re0;
  logic                re1;
  logic [ADDR_W-1:0]   raddr0;
  logic [ADDR_W-1:0]   raddr1;
  logic [WIDTH-1:0]    rdata0;
  logic [WIDTH-1:0]    rdata1;
  logic                rvalid0;
  logic                rvalid1;
  logic [DEPTH-1:0]    entry_valid;
  logic                clr_req;
  logic                clr_busy;
  logic                clr_done;

  modport master (
    output we, waddr, wdata, wbe, re0, re1, raddr0, raddr1, clr_req,
    input  wr_err, rdata0, rdata1, rvalid0, rvalid1, entry_valid, clr_busy, clr_done
  );

  modport slave (
    input  we, waddr, wdata, wbe, re0, re1, raddr0, raddr1, clr_req,
    output wr_err, rdata0, rdata1, rvalid0, rvalid1, entry_valid, clr_busy, clr_done
  );

endinterface

// File: rtl/bit_vault_rd_port.sv
// rtl/bit_vault_rd_port.sv - one registered read port with write/clear forwarding
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   re, raddr            read request
//   rd_word              current storage word at raddr (0 when out of range)
//   wr_hit/addr/word     accepted write this cycle and its merged word
//   clr_hit, clr_addr    sweep clearing clr_addr this cycle
//   rdata, rvalid        registered read result
module bit_vault_rd_port
  import bit_vault_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2,
  parameter int BYPASS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  input  logic [WIDTH-1:0]  rd_word,
  input  logic              wr_hit,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_word,
  input  logic              clr_hit,
  input  logic [ADDR_W-1:0] clr_addr,
  output logic [WIDTH-1:0]  rdata,
  output logic              rvalid
);

  logic [WIDTH-1:0] next_word;

  // Writes are dropped while sweeping, so the two forwarding sources
  // never overlap; clear is checked first only for clarity.
  always_comb begin
    next_word = rd_word;
    if (BYPASS != 0) begin
      if (clr_hit && (raddr == clr_addr)) begin
        next_word = '0;
      end else if (wr_hit && (raddr == wr_addr)) begin
        next_word = wr_word;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata  <= '0;
      rvalid <= 1'b0;
    end else begin
      rvalid <= re;
      if (re) rdata <= next_word;
    end
  end

endmodule

// File: rtl/bit_vault_rf.sv
// rtl/bit_vault_rf.sv - WIDTH x DEPTH register file with byte-enabled write, two reads, bulk clear
// Ports:
//   clk  clock, all logic on rising edge
//   rst  synchronous active-high reset, aborts any sweep
//   bus  bit_vault_rf_if.slave: write port, two read ports, entry_valid, clear control
module bit_vault_rf
  import bit_vault_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 4,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  bit_vault_rf_if.slave bus
);

  localparam int                ADDR_W   = $clog2(DEPTH);
  localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [DEPTH-1:0]  valid_q;
  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              busy_q, busy_d, done_q, done_d, wr_err_q;
  logic              wr_in_range, wr_ok, sweep;
  logic [WIDTH-1:0]  wr_old, wr_merged, rd_word0, rd_word1;

  assign sweep       = (state_q == CLR_SWEEP);
  assign wr_in_range = ({1'b0, bus.waddr} < DEPTH_X);
  assign wr_ok       = bus.we && !busy_q && wr_in_range;

  assign wr_old    = wr_in_range ? mem[bus.waddr] : '0;
  assign wr_merged = WIDTH'(merge_be(MERGE_W'(wr_old), MERGE_W'(bus.wdata), MERGE_BE'(bus.wbe)));

  assign rd_word0 = ({1'b0, bus.raddr0} < DEPTH_X) ? mem[bus.raddr0] : '0;
  assign rd_word1 = ({1'b0, bus.raddr1} < DEPTH_X) ? mem[bus.raddr1] : '0;

  // Clear sequencer; busy/done are registered from the next state so they
  // track the state register exactly without decode glitches.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      CLR_IDLE: begin
        if (bus.clr_req) begin
          state_d = CLR_SWEEP;
          idx_d   = '0;
        end
      end
      CLR_SWEEP: begin
        if (idx_q == LAST_IDX) state_d = CLR_DONE;
        else                   idx_d   = idx_q + ADDR_W'(1);
      end
      CLR_DONE: state_d = CLR_IDLE;
      default:  state_d = CLR_IDLE;
    endcase
    busy_d = (state_d == CLR_SWEEP);
    done_d = (state_d == CLR_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= CLR_IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wr_err_q <= 1'b0;
      valid_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      wr_err_q <= bus.we && !wr_ok;
      // wr_ok excludes sweep cycles, so these two updates never collide.
      if (wr_ok) begin
        mem[bus.waddr]     <= wr_merged;
        valid_q[bus.waddr] <= 1'b1;
      end
      if (sweep) begin
        mem[idx_q]     <= '0;
        valid_q[idx_q] <= 1'b0;
      end
    end
  end

  assign bus.wr_err      = wr_err_q;
  assign bus.entry_valid = valid_q;
  assign bus.clr_busy    = busy_q;
  assign bus.clr_done    = done_q;

  bit_vault_rd_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd0 (
    .clk(clk), .rst(rst), .re(bus.re0), .raddr(bus.raddr0), .rd_word(rd_word0),
    .wr_hit(wr_ok), .wr_addr(bus.waddr), .wr_word(wr_merged),
    .clr_hit(sweep), .clr_addr(idx_q), .rdata(bus.rdata0), .rvalid(bus.rvalid0)
  );

  bit_vault_rd_port #(.WIDTH(WIDTH), .ADDR_W(ADDR_W), .BYPASS(BYPASS)) u_rd1 (
    .clk(clk), .rst(rst), .re(bus.re1), .raddr(bus.raddr1), .rd_word(rd_word1),
    .wr_hit(wr_ok), .wr_addr(bus.waddr), .wr_word(wr_merged),
    .clr_hit(sweep), .clr_addr(idx_q), .rdata(bus.rdata1), .rvalid(bus.rvalid1)
  );

endmodule

// File: tb/tb_bit_vault_rf.sv
// tb/tb_bit_vault_rf.sv - directed bench for bit_vault_rf (16x4 bypass and 8x5 no-bypass)
module tb_bit_vault_rf;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  bit_vault_rf_if #(.WIDTH(16), .DEPTH(4)) ifa ();
  bit_vault_rf_if #(.WIDTH(8),  .DEPTH(5)) ifb ();

  bit_vault_rf #(.WIDTH(16), .DEPTH(4), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  bit_vault_rf #(.WIDTH(8),  .DEPTH(5), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));

  typedef struct {
    logic        we;
    logic [1:0]  wa;
    logic [15:0] wd;
    logic [1:0]  be;
    logic        re0;
    logic [1:0]  ra0;
    logic        re1;
    logic [1:0]  ra1;
    logic        clr;
    logic [15:0] r0;
    logic        v0;
    logic [15:0] r1;
    logic        v1;
    logic        err;
    logic [3:0]  valid;
    logic        busy;
    logic        done;
  } vec_t;

  vec_t vt [16];

  function automatic vec_t mk(int we, int wa, int wd, int be, int re0, int ra0, int re1, int ra1,
                              int clr, int r0, int v0, int r1, int v1, int err, int valid,
                              int busy, int done);
    vec_t v;
    v.we = 1'(we);   v.wa = 2'(wa);   v.wd = 16'(wd); v.be = 2'(be);
    v.re0 = 1'(re0); v.ra0 = 2'(ra0); v.re1 = 1'(re1); v.ra1 = 2'(ra1);
    v.clr = 1'(clr); v.r0 = 16'(r0);  v.v0 = 1'(v0);   v.r1 = 16'(r1); v.v1 = 1'(v1);
    v.err = 1'(err); v.valid = 4'(valid); v.busy = 1'(busy); v.done = 1'(done);
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    ifa.we = 0; ifa.waddr = '0; ifa.wdata = '0; ifa.wbe = '0;
    ifa.re0 = 0; ifa.raddr0 = '0; ifa.re1 = 0; ifa.raddr1 = '0; ifa.clr_req = 0;
  endtask

  task automatic idle_b();
    ifb.we = 0; ifb.waddr = '0; ifb.wdata = '0; ifb.wbe = '0;
    ifb.re0 = 0; ifb.raddr0 = '0; ifb.re1 = 0; ifb.raddr1 = '0; ifb.clr_req = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [6:0] busy_pat;
    logic [6:0] done_pat;
    int         done_seen;

    //           we wa wd        be    re0 ra0 re1 ra1 clr r0        v0 r1        v1 err valid   busy done
    vt[0]  = mk(0, 0, 0,        0,    1, 0, 1, 1,  0,  0,        1, 0,        1, 0, 4'b0000, 0, 0);
    vt[1]  = mk(0, 0, 0,        0,    1, 2, 1, 3,  0,  0,        1, 0,        1, 0, 4'b0000, 0, 0);
    vt[2]  = mk(1, 2, 16'hABCD, 2'b11, 0, 0, 0, 0, 0,  0,        0, 0,        0, 0, 4'b0100, 0, 0);
    vt[3]  = mk(1, 2, 16'h1234, 2'b01, 1, 2, 0, 0, 0,  16'hAB34, 1, 0,        0, 0, 4'b0100, 0, 0);
    vt[4]  = mk(0, 0, 0,        0,    1, 2, 1, 2,  0,  16'hAB34, 1, 16'hAB34, 1, 0, 4'b0100, 0, 0);
    vt[5]  = mk(1, 1, 16'h0011, 2'b11, 0, 0, 0, 0, 0,  16'hAB34, 0, 16'hAB34, 0, 0, 4'b0110, 0, 0);
    vt[6]  = mk(1, 1, 16'h0055, 2'b11, 1, 1, 1, 1, 0,  16'h0055, 1, 16'h0055, 1, 0, 4'b0110, 0, 0);
    vt[7]  = mk(1, 0, 16'hFFFF, 2'b00, 1, 0, 0, 0, 0,  0,        1, 16'h0055, 0, 0, 4'b0111, 0, 0);
    vt[8]  = mk(1, 3, 16'h8001, 2'b10, 0, 0, 1, 3, 0,  0,        0, 16'h8000, 1, 0, 4'b1111, 0, 0);
    vt[9]  = mk(1, 0, 16'h7777, 2'b11, 1, 0, 0, 0, 1,  16'h7777, 1, 16'h8000, 0, 0, 4'b1111, 1, 0);
    vt[10] = mk(1, 1, 16'h1111, 2'b11, 1, 0, 1, 1, 0,  0,        1, 16'h0055, 1, 1, 4'b1110, 1, 0);
    vt[11] = mk(0, 0, 0,        0,    1, 1, 1, 3,  1,  0,        1, 16'h8000, 1, 0, 4'b1100, 1, 0);
    vt[12] = mk(0, 0, 0,        0,    1, 2, 0, 0,  0,  0,        1, 16'h8000, 0, 0, 4'b1000, 1, 0);
    vt[13] = mk(0, 0, 0,        0,    1, 0, 1, 3,  0,  0,        1, 0,        1, 0, 4'b0000, 0, 1);
    vt[14] = mk(0, 0, 0,        0,    1, 1, 1, 2,  1,  0,        1, 0,        1, 0, 4'b0000, 0, 0);
    vt[15] = mk(0, 0, 0,        0,    1, 3, 0, 0,  0,  0,        1, 0,        0, 0, 4'b0000, 0, 0);

    rst = 1'b1;
    idle_a();
    idle_b();
    step();
    step();
    chk("reset a", 64'({ifa.rdata0, ifa.rvalid0, ifa.rdata1, ifa.rvalid1, ifa.wr_err,
                        ifa.entry_valid, ifa.clr_busy, ifa.clr_done}), 64'(0));
    chk("reset b", 64'({ifb.rdata0, ifb.rvalid0, ifb.rdata1, ifb.rvalid1, ifb.wr_err,
                        ifb.entry_valid, ifb.clr_busy, ifb.clr_done}), 64'(0));
    rst = 1'b0;

    for (int i = 0; i < 16; i++) begin
      ifa.we = vt[i].we;   ifa.waddr = vt[i].wa;   ifa.wdata = vt[i].wd; ifa.wbe = vt[i].be;
      ifa.re0 = vt[i].re0; ifa.raddr0 = vt[i].ra0; ifa.re1 = vt[i].re1;  ifa.raddr1 = vt[i].ra1;
      ifa.clr_req = vt[i].clr;
      step();
      chk($sformatf("vec%0d port0", i), 64'({ifa.rdata0, ifa.rvalid0}), 64'({vt[i].r0, vt[i].v0}));
      chk($sformatf("vec%0d port1", i), 64'({ifa.rdata1, ifa.rvalid1}), 64'({vt[i].r1, vt[i].v1}));
      chk($sformatf("vec%0d ctrl", i),
          64'({ifa.wr_err, ifa.entry_valid, ifa.clr_busy, ifa.clr_done}),
          64'({vt[i].err, vt[i].valid, vt[i].busy, vt[i].done}));
    end
    idle_a();

    // clr_req held high: sweep, done, ignored in DONE, restart from IDLE
    busy_pat = 7'b1001111;
    done_pat = 7'b0010000;
    ifa.clr_req = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      chk($sformatf("held clr cycle%0d", i), 64'({ifa.clr_busy, ifa.clr_done}),
          64'({busy_pat[i], done_pat[i]}));
    end
    ifa.clr_req = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("reset ends held sweep", 64'({ifa.clr_busy, ifa.clr_done}), 64'(0));

    // reset at sweep cycle 2 with live data
    ifa.we = 1'b1; ifa.wbe = 2'b11;
    for (int a = 1; a < 4; a++) begin
      ifa.waddr = 2'(a);
      ifa.wdata = 16'(16'h1111 * (a + 9));
      step();
    end
    ifa.we = 1'b0;
    chk("prefill valid", 64'(ifa.entry_valid), 64'(4'b1110));
    ifa.clr_req = 1'b1;
    step();
    chk("abort sweep busy1", 64'(ifa.clr_busy), 64'(1));
    ifa.clr_req = 1'b0;
    step();
    chk("abort sweep busy2", 64'({ifa.clr_busy, ifa.entry_valid}), 64'({1'b1, 4'b1110}));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort reset state", 64'({ifa.clr_busy, ifa.clr_done, ifa.entry_valid}), 64'(0));
    done_seen = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (ifa.clr_done) done_seen++;
    end
    chk("abort no done pulse", 64'(done_seen), 64'(0));
    for (int a = 0; a < 4; a++) begin
      ifa.re0 = 1'b1; ifa.raddr0 = 2'(a);
      ifa.re1 = 1'b1; ifa.raddr1 = 2'(a);
      step();
      chk($sformatf("abort read addr%0d", a),
          64'({ifa.rdata0, ifa.rvalid0, ifa.rdata1, ifa.rvalid1}), 64'({16'h0, 1'b1, 16'h0, 1'b1}));
    end
    idle_a();
    ifa.we = 1'b1; ifa.waddr = 2'd0; ifa.wdata = 16'h0101; ifa.wbe = 2'b11;
    step();
    ifa.we = 1'b0;
    chk("abort idle accepts write", 64'({ifa.wr_err, ifa.entry_valid}), 64'({1'b0, 4'b0001}));
    idle_a();

    // 8x5, no bypass
    ifb.we = 1'b1; ifb.waddr = 3'd1; ifb.wdata = 8'h11; ifb.wbe = 1'b1;
    step();
    chk("b write1", 64'({ifb.wr_err, ifb.entry_valid}), 64'({1'b0, 5'b00010}));
    ifb.wdata = 8'h55;
    ifb.re0 = 1'b1; ifb.raddr0 = 3'd1; ifb.re1 = 1'b1; ifb.raddr1 = 3'd1;
    step();
    chk("b nobypass port0", 64'({ifb.rdata0, ifb.rvalid0}), 64'({8'h11, 1'b1}));
    chk("b nobypass port1", 64'({ifb.rdata1, ifb.rvalid1}), 64'({8'h11, 1'b1}));
    ifb.we = 1'b0; ifb.re1 = 1'b0;
    step();
    chk("b readback", 64'({ifb.rdata0, ifb.rvalid0, ifb.rvalid1}), 64'({8'h55, 1'b1, 1'b0}));
    ifb.re0 = 1'b0;
    ifb.we = 1'b1; ifb.waddr = 3'd6; ifb.wdata = 8'hEE;
    step();
    chk("b oor wr_err", 64'({ifb.wr_err, ifb.entry_valid}), 64'({1'b1, 5'b00010}));
    ifb.we = 1'b0;
    ifb.re0 = 1'b1; ifb.raddr0 = 3'd6; ifb.re1 = 1'b1; ifb.raddr1 = 3'd4;
    step();
    chk("b wr_err one cycle", 64'(ifb.wr_err), 64'(0));
    chk("b oor read", 64'({ifb.rdata0, ifb.rvalid0, ifb.rdata1, ifb.rvalid1}),
        64'({8'h00, 1'b1, 8'h00, 1'b1}));
    ifb.raddr0 = 3'd1; ifb.re1 = 1'b0;
    step();
    chk("b storage kept", 64'({ifb.rdata0, ifb.rvalid0}), 64'({8'h55, 1'b1}));
    ifb.re0 = 1'b0;
    ifb.clr_req = 1'b1;
    step();
    chk("b sweep start", 64'({ifb.clr_busy, ifb.clr_done}), 64'({1'b1, 1'b0}));
    ifb.clr_req = 1'b0;
    step();
    ifb.re0 = 1'b1; ifb.raddr0 = 3'd1;
    step();
    chk("b read during clear", 64'({ifb.rdata0, ifb.rvalid0, ifb.clr_busy}), 64'({8'h55, 1'b1, 1'b1}));
    ifb.re0 = 1'b0;
    step();
    step();
    chk("b sweep last", 64'({ifb.clr_busy, ifb.clr_done}), 64'({1'b1, 1'b0}));
    step();
    chk("b sweep done", 64'({ifb.clr_busy, ifb.clr_done, ifb.entry_valid}), 64'({1'b0, 1'b1, 5'b0}));
    step();
    chk("b done one cycle", 64'({ifb.clr_busy, ifb.clr_done}), 64'(0));
    ifb.re0 = 1'b1; ifb.raddr0 = 3'd1;
    step();
    chk("b cleared read", 64'({ifb.rdata0, ifb.rvalid0}), 64'({8'h00, 1'b1}));
    idle_b();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
